// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit and memory.
interface load_store_unit_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, we, addr, wdata, be, input ack, rdata);
   modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/load_store_unit.sv
// Memory access stage: aligns stores, extends loads, runs one req/ack transfer
// at a time and reports misaligned, illegal-width and timeout faults.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid_i,
   input  logic               req_load_i,
   input  logic [2:0]         funct3_i,
   input  logic [31:0]        addr_i,
   input  logic [31:0]        store_data_i,
   output logic               stall_o,
   output logic               done_o,
   output logic [31:0]        load_data_o,
   output logic               misaligned_o,
   output logic               bus_err_o,
   load_store_unit_if.master  mem
);
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               load_q, load_d;
   logic [2:0]         funct3_q, funct3_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         be_q, be_d;
   logic               done_q, done_d;
   logic [31:0]        load_data_q, load_data_d;
   logic               mis_q, mis_d;
   logic               berr_q, berr_d;

   logic               illegal_c, misalign_c;
   logic [3:0]         be_c;
   logic [31:0]        wdata_c, lane_c, ext_c;

   // Request decode: fault classification and lane alignment of the incoming access
   always_comb begin
      illegal_c  = (funct3_i[1:0] == 2'b11) || (funct3_i == 3'b110) ||
                   (!req_load_i && funct3_i[2]);
      misalign_c = !illegal_c &&
                   (((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                    ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)));
      be_c    = 4'b1111;
      wdata_c = store_data_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_c    = 4'(4'b0001 << addr_i[1:0]);
            wdata_c = {4{store_data_i[7:0]}};
         end
         2'b01: begin
            be_c    = 4'(4'b0011 << addr_i[1:0]);
            wdata_c = {2{store_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Load extraction from the addressed lane of the returned word
   always_comb begin
      lane_c = mem.rdata >> {addr_q[1:0], 3'b000};
      case (funct3_q)
         3'b000:  ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
         3'b100:  ext_c = {24'h0, lane_c[7:0]};
         3'b001:  ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
         3'b101:  ext_c = {16'h0, lane_c[15:0]};
         default: ext_c = lane_c;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      load_d      = load_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      done_d      = 1'b0;
      load_data_d = load_data_q;
      mis_d       = mis_q;
      berr_d      = berr_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               load_d      = req_load_i;
               funct3_d    = funct3_i;
               addr_d      = addr_i;
               wdata_d     = wdata_c;
               be_d        = be_c;
               load_data_d = '0;
               mis_d       = misalign_c;
               berr_d      = illegal_c;
               if (illegal_c || misalign_c) begin
                  state_d = S_RESP;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_BUS;
                  cnt_d   = '0;
               end
            end
         end
         S_BUS: begin
            // An ack in the final counted cycle still completes normally
            if (mem.ack) begin
               load_data_d = load_q ? ext_c : '0;
               state_d     = S_RESP;
               done_d      = 1'b1;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               berr_d  = 1'b1;
               state_d = S_RESP;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            state_d     = S_IDLE;
            load_data_d = '0;
            mis_d       = 1'b0;
            berr_d      = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         load_q      <= 1'b0;
         funct3_q    <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         done_q      <= 1'b0;
         load_data_q <= '0;
         mis_q       <= 1'b0;
         berr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         load_q      <= load_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         done_q      <= done_d;
         load_data_q <= load_data_d;
         mis_q       <= mis_d;
         berr_q      <= berr_d;
      end
   end

   assign stall_o      = ((state_q == S_IDLE) && req_valid_i) || (state_q == S_BUS);
   assign done_o       = done_q;
   assign load_data_o  = load_data_q;
   assign misaligned_o = mis_q;
   assign bus_err_o    = berr_q;

   assign mem.req   = (state_q == S_BUS);
   assign mem.we    = (state_q == S_BUS) && !load_q;
   assign mem.addr  = {addr_q[31:2], 2'b00};
   assign mem.wdata = wdata_q;
   assign mem.be    = be_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 4-cycle bus timeout.
module tb_load_store_unit;
   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_load;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        stall;
   logic        done;
   logic [31:0] load_data;
   logic        misaligned;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   load_store_unit_if mem_bus ();

   load_store_unit #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid),
      .req_load_i   (req_load),
      .funct3_i     (funct3),
      .addr_i       (addr),
      .store_data_i (store_data),
      .stall_o      (stall),
      .done_o       (done),
      .load_data_o  (load_data),
      .misaligned_o (misaligned),
      .bus_err_o    (bus_err),
      .mem          (mem_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Present a request at a negedge; the following posedge is the accept edge.
   task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd);
      req_valid  = 1'b1;
      req_load   = ld;
      funct3     = f3;
      addr       = a;
      store_data = sd;
   endtask

   task automatic test_reset;
      rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; funct3 = 3'b000;
      addr = '0; store_data = '0; mem_bus.ack = 1'b0; mem_bus.rdata = '0;
      repeat (3) @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
      checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL rst_load_data got %h exp 0", load_data); end
      checks++; if ({misaligned, bus_err} !== 2'b00) begin errors++; $display("FAIL rst_faults got %b exp 00", {misaligned, bus_err}); end
      checks++; if ({mem_bus.req, mem_bus.we} !== 2'b00) begin errors++; $display("FAIL rst_req_we got %b exp 00", {mem_bus.req, mem_bus.we}); end
      checks++; if ({mem_bus.addr, mem_bus.wdata, mem_bus.be} !== 68'h0) begin errors++; $display("FAIL rst_bus got %h exp 0", {mem_bus.addr, mem_bus.wdata, mem_bus.be}); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall_lo got %b exp 0", stall); end
      req_valid = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_stall_hi got %b exp 1", stall); end
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_lw;
      issue(1'b1, 3'b010, 32'h0000_0100, 32'h0);
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_t0_stall got %b exp 1", stall); end
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if ({mem_bus.req, mem_bus.we, stall, done} !== 4'b1010) begin errors++; $display("FAIL lw_t1_ctrl got %b exp 1010", {mem_bus.req, mem_bus.we, stall, done}); end
      checks++; if (mem_bus.addr !== 32'h0000_0100) begin errors++; $display("FAIL lw_addr got %h exp 00000100", mem_bus.addr); end
      checks++; if (mem_bus.be !== 4'b1111) begin errors++; $display("FAIL lw_be got %b exp 1111", mem_bus.be); end
      mem_bus.ack = 1'b1; mem_bus.rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_bus.ack = 1'b0;
      checks++; if ({done, stall, mem_bus.req, misaligned, bus_err} !== 5'b10000) begin errors++; $display("FAIL lw_t2_ctrl got %b exp 10000", {done, stall, mem_bus.req, misaligned, bus_err}); end
      checks++; if (load_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", load_data); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL lw_done_pulse got %b exp 0", done); end
   endtask

   task automatic test_sub_word_loads;
      logic [2:0]  f3_t [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
      logic [31:0] a_t  [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
      logic [3:0]  be_t [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0001};
      logic [31:0] d_t  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF,
                                32'hFFFF_80FF, 32'h0000_0000};
      for (int i = 0; i < 5; i++) begin
         issue(1'b1, f3_t[i], a_t[i], 32'h0);
         @(negedge clk);
         req_valid = 1'b0;
         checks++; if ({mem_bus.req, mem_bus.be} !== {1'b1, be_t[i]}) begin errors++; $display("FAIL ld%0d_be got %b exp %b", i, {mem_bus.req, mem_bus.be}, {1'b1, be_t[i]}); end
         mem_bus.ack = 1'b1; mem_bus.rdata = 32'h80FF_FF00;
         @(negedge clk);
         mem_bus.ack = 1'b0;
         checks++; if ({done, load_data} !== {1'b1, d_t[i]}) begin errors++; $display("FAIL ld%0d_data got %b/%h exp 1/%h", i, done, load_data, d_t[i]); end
         @(negedge clk);
      end
   endtask

   task automatic test_stores;
      logic [2:0]  f3_t [3] = '{3'b000, 3'b001, 3'b010};
      logic [31:0] a_t  [3] = '{32'h101, 32'h102, 32'h104};
      logic [31:0] w_t  [3] = '{32'h7878_7878, 32'h5678_5678, 32'h1234_5678};
      logic [3:0]  be_t [3] = '{4'b0010, 4'b1100, 4'b1111};
      logic [31:0] ma_t [3] = '{32'h100, 32'h100, 32'h104};
      for (int i = 0; i < 3; i++) begin
         issue(1'b0, f3_t[i], a_t[i], 32'h1234_5678);
         @(negedge clk);
         req_valid = 1'b0;
         checks++; if ({mem_bus.req, mem_bus.we, mem_bus.be} !== {2'b11, be_t[i]}) begin errors++; $display("FAIL st%0d_ctrl got %b exp %b", i, {mem_bus.req, mem_bus.we, mem_bus.be}, {2'b11, be_t[i]}); end
         checks++; if ({mem_bus.addr, mem_bus.wdata} !== {ma_t[i], w_t[i]}) begin errors++; $display("FAIL st%0d_addr_wdata got %h exp %h", i, {mem_bus.addr, mem_bus.wdata}, {ma_t[i], w_t[i]}); end
         mem_bus.ack = 1'b1; mem_bus.rdata = 32'hFFFF_FFFF;
         @(negedge clk);
         mem_bus.ack = 1'b0;
         checks++; if ({done, load_data, bus_err} !== {1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL st%0d_done got %b/%h/%b exp 1/0/0", i, done, load_data, bus_err); end
         @(negedge clk);
      end
   endtask

   task automatic test_faults;
      logic       ld_t  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [2:0] f3_t  [4] = '{3'b010, 3'b100, 3'b011, 3'b001};
      logic [31:0] a_t  [4] = '{32'h102, 32'h100, 32'h100, 32'h101};
      logic [1:0] exp_t [4] = '{2'b10, 2'b01, 2'b01, 2'b10};
      for (int i = 0; i < 4; i++) begin
         issue(ld_t[i], f3_t[i], a_t[i], 32'hFFFF_FFFF);
         mem_bus.rdata = 32'hAAAA_AAAA;
         #1;
         checks++; if ({stall, mem_bus.req} !== 2'b10) begin errors++; $display("FAIL flt%0d_t0 got %b exp 10", i, {stall, mem_bus.req}); end
         @(negedge clk);
         req_valid = 1'b0;
         checks++; if ({done, mem_bus.req, stall, misaligned, bus_err} !== {3'b100, exp_t[i]}) begin errors++; $display("FAIL flt%0d_t1 got %b exp %b", i, {done, mem_bus.req, stall, misaligned, bus_err}, {3'b100, exp_t[i]}); end
         checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL flt%0d_data got %h exp 0", i, load_data); end
         @(negedge clk);
         checks++; if ({done, mem_bus.req} !== 2'b00) begin errors++; $display("FAIL flt%0d_after got %b exp 00", i, {done, mem_bus.req}); end
      end
   endtask

   task automatic test_timeout;
      int req_cycles;
      issue(1'b1, 3'b010, 32'h200, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      req_cycles = 0;
      for (int c = 0; c < 6 && mem_bus.req === 1'b1; c++) begin
         req_cycles++;
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL to_early_done cyc %0d got %b exp 0", c, done); end
         @(negedge clk);
      end
      checks++; if (req_cycles !== 4) begin errors++; $display("FAIL to_req_len got %0d exp 4", req_cycles); end
      checks++; if ({done, bus_err, misaligned, load_data} !== {3'b110, 32'h0}) begin errors++; $display("FAIL to_resp got %b/%h exp 110/0", {done, bus_err, misaligned}, load_data); end
      mem_bus.ack = 1'b1; mem_bus.rdata = 32'h5555_5555;
      @(negedge clk);
      mem_bus.ack = 1'b0;
      checks++; if ({done, bus_err, mem_bus.req, stall, load_data} !== {4'b0000, 32'h0}) begin errors++; $display("FAIL to_late_ack got %b/%h exp 0000/0", {done, bus_err, mem_bus.req, stall}, load_data); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL to_late_ack_done got %b exp 0", done); end
   endtask

   task automatic test_ack_last_cycle;
      issue(1'b1, 3'b010, 32'h204, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({mem_bus.req, done} !== 2'b10) begin errors++; $display("FAIL ack4_req got %b exp 10", {mem_bus.req, done}); end
      mem_bus.ack = 1'b1; mem_bus.rdata = 32'h1122_3344;
      @(negedge clk);
      mem_bus.ack = 1'b0;
      checks++; if ({done, bus_err, load_data} !== {2'b10, 32'h1122_3344}) begin errors++; $display("FAIL ack4_resp got %b/%h exp 10/11223344", {done, bus_err}, load_data); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_bus;
      issue(1'b0, 3'b010, 32'h300, 32'hCAFE_F00D);
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if ({mem_bus.req, mem_bus.we, mem_bus.wdata} !== {2'b11, 32'hCAFE_F00D}) begin errors++; $display("FAIL rmb_w1 got %b/%h exp 11/cafef00d", {mem_bus.req, mem_bus.we}, mem_bus.wdata); end
      @(negedge clk);
      checks++; if (mem_bus.req !== 1'b1) begin errors++; $display("FAIL rmb_w2 got %b exp 1", mem_bus.req); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if ({mem_bus.req, mem_bus.we, done, stall} !== 4'b0000) begin errors++; $display("FAIL rmb_after got %b exp 0000", {mem_bus.req, mem_bus.we, done, stall}); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmb_no_done got %b exp 0", done); end
      issue(1'b1, 3'b010, 32'h100, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if ({mem_bus.req, mem_bus.we, mem_bus.addr} !== {2'b10, 32'h100}) begin errors++; $display("FAIL rmb_lw_bus got %b/%h exp 10/00000100", {mem_bus.req, mem_bus.we}, mem_bus.addr); end
      mem_bus.ack = 1'b1; mem_bus.rdata = 32'h0BAD_C0DE;
      @(negedge clk);
      mem_bus.ack = 1'b0;
      checks++; if ({done, bus_err, load_data} !== {2'b10, 32'h0BAD_C0DE}) begin errors++; $display("FAIL rmb_lw_done got %b/%h exp 10/0badc0de", {done, bus_err}, load_data); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sub_word_loads();
      test_stores();
      test_faults();
      test_timeout();
      test_ack_last_cycle();
      test_reset_mid_bus();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
